pong_frame_engine: RTL

- Pong game-state and pixel-colour stage that sits directly downstream of the VGA timing controller.
- Consumes the controller's nextX/nextY/blank_n/vSync_n. Once per frame (vSync_n falling edge) it updates paddle and ball positions and scores.
- Every clock it produces the registered RGB colour for the current pixel, which goes to the DAC.
- Screen is 800x600. Ball and paddle coordinates are the top-left corner, 12-bit unsigned.

---
 rtl/pong_frame_engine.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/pong_frame_engine.sv
// Pong game state (paddles, ball, scores) updated once per frame plus a registered pixel-colour stage.
// Optional build macro PONG_AI_EN: the right paddle follows the ball instead of rUp/rDown.
module pong_frame_engine #(
  parameter int BALL_SIZE     = 8,
  parameter int BALL_SPEED    = 4,
  parameter int PADDLE_W      = 8,
  parameter int PADDLE_H      = 64,
  parameter int PADDLE_SPEED  = 6,
  parameter int PADDLE_MARGIN = 16,
  parameter int SERVE_FRAMES  = 60
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [11:0] nextX,
  input  logic [11:0] nextY,
  input  logic        blank_n,
  input  logic        vSync_n,
  input  logic        lUp,
  input  logic        lDown,
  input  logic        rUp,
  input  logic        rDown,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic [3:0]  scoreL,
  output logic [3:0]  scoreR,
  output logic        frameTick,
  output logic [1:0]  dbg_state_o,
  output logic [11:0] dbg_ball_x_o,
  output logic [11:0] dbg_ball_y_o,
  output logic [11:0] dbg_lpad_y_o,
  output logic [11:0] dbg_rpad_y_o
);

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  // Every coordinate sum below stays under 4096, so 12-bit arithmetic never wraps.
  localparam logic [11:0] SCR_W      = 12'd800;
  localparam logic [11:0] SCR_H      = 12'd600;
  localparam logic [11:0] BS         = 12'(BALL_SIZE);
  localparam logic [11:0] BV         = 12'(BALL_SPEED);
  localparam logic [11:0] PW         = 12'(PADDLE_W);
  localparam logic [11:0] PH         = 12'(PADDLE_H);
  localparam logic [11:0] PV         = 12'(PADDLE_SPEED);
  localparam logic [11:0] LP_X       = 12'(PADDLE_MARGIN);
  localparam logic [11:0] LP_R       = 12'(PADDLE_MARGIN + PADDLE_W);
  localparam logic [11:0] RP_L       = 12'(800 - PADDLE_MARGIN - PADDLE_W);
  localparam logic [11:0] BALL_Y_MAX = 12'(600 - BALL_SIZE);
  localparam logic [11:0] PAD_Y_MAX  = 12'(600 - PADDLE_H);
  localparam logic [11:0] BALL_X0    = 12'((800 - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_Y0    = 12'((600 - BALL_SIZE) / 2);
  localparam logic [11:0] PAD_Y0     = 12'((600 - PADDLE_H) / 2);
  localparam logic [11:0] LINE_X0    = 12'd398;
  localparam logic [11:0] LINE_X1    = 12'd401;

  logic          vs_q, frame_tick_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic          dir_r_q, dir_r_d, dir_d_q, dir_d_d;
  logic          scorer_l_q, scorer_l_d;
  logic [11:0]   lpad_q, lpad_d, rpad_q, rpad_d;
  logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0]    pix_q, pix_d;
  logic          tick, ov_l, ov_r, r_up, r_dn;
  logic          in_ball, in_lpad, in_rpad, in_line;

  function automatic logic [11:0] pad_step(input logic [11:0] y, input logic up, input logic dn);
    logic [11:0] r;
    r = y;
    if (up && !dn)      r = (y < PV) ? 12'd0 : y - PV;
    else if (dn && !up) r = (y + PV > PAD_Y_MAX) ? PAD_Y_MAX : y + PV;
    return r;
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] s);
    return (s == 4'd9) ? 4'd0 : s + 4'd1;
  endfunction

  assign tick = vs_q & ~vSync_n;

`ifdef PONG_AI_EN
  logic [11:0] ai_pad_c, ai_ball_c;
  logic        ai_unused_buttons;
  assign ai_unused_buttons = rUp ^ rDown;
  assign ai_pad_c  = rpad_q + PH / 12'd2;
  assign ai_ball_c = ball_y_q + BS / 12'd2;
  assign r_up      = ai_pad_c > ai_ball_c + PV;
  assign r_dn      = ai_pad_c + PV < ai_ball_c;
`else
  assign r_up = rUp;
  assign r_dn = rDown;
`endif

  // Hit tests use the positions from before this frame's move.
  assign ov_l = (ball_y_q + BS > lpad_q) && (ball_y_q < lpad_q + PH);
  assign ov_r = (ball_y_q + BS > rpad_q) && (ball_y_q < rpad_q + PH);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dir_r_d    = dir_r_q;
    dir_d_d    = dir_d_q;
    scorer_l_d = scorer_l_q;
    lpad_d     = lpad_q;
    rpad_d     = rpad_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    if (tick) begin
      lpad_d = pad_step(lpad_q, lUp, lDown);
      rpad_d = pad_step(rpad_q, r_up, r_dn);
      case (state_q)
        ST_SERVE: begin
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_PLAY: begin
          if (dir_d_q) begin
            if (ball_y_q + BV >= BALL_Y_MAX) begin
              ball_y_d = BALL_Y_MAX;
              dir_d_d  = 1'b0;
            end else begin
              ball_y_d = ball_y_q + BV;
            end
          end else if (ball_y_q <= BV) begin
            ball_y_d = 12'd0;
            dir_d_d  = 1'b1;
          end else begin
            ball_y_d = ball_y_q - BV;
          end
          if (!dir_r_q) begin
            if (ball_x_q >= LP_R && ball_x_q <= LP_R + BV && ov_l) begin
              ball_x_d = LP_R;
              dir_r_d  = 1'b1;
            end else if (ball_x_q <= BV) begin
              state_d    = ST_POINT;
              scorer_l_d = 1'b0;
            end else begin
              ball_x_d = ball_x_q - BV;
            end
          end else begin
            if (ball_x_q + BS <= RP_L && ball_x_q + BS + BV >= RP_L && ov_r) begin
              ball_x_d = RP_L - BS;
              dir_r_d  = 1'b0;
            end else if (ball_x_q + BS + BV >= SCR_W) begin
              state_d    = ST_POINT;
              scorer_l_d = 1'b1;
            end else begin
              ball_x_d = ball_x_q + BV;
            end
          end
        end
        ST_POINT: begin
          if (scorer_l_q) score_l_d = bcd_inc(score_l_q);
          else            score_r_d = bcd_inc(score_r_q);
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          // Serve toward the player who conceded.
          dir_r_d  = scorer_l_q;
          state_d  = ST_SERVE;
        end
        default: state_d = ST_SERVE;
      endcase
    end
  end

  assign in_ball = (nextX >= ball_x_q) && (nextX < ball_x_q + BS) &&
                   (nextY >= ball_y_q) && (nextY < ball_y_q + BS);
  assign in_lpad = (nextX >= LP_X) && (nextX < LP_R) &&
                   (nextY >= lpad_q) && (nextY < lpad_q + PH);
  assign in_rpad = (nextX >= RP_L) && (nextX < RP_L + PW) &&
                   (nextY >= rpad_q) && (nextY < rpad_q + PH);
  assign in_line = (nextX >= LINE_X0) && (nextX <= LINE_X1) && !nextY[4];

  always_comb begin
    pix_d = 8'h00;
    if (blank_n) begin
      if (in_ball || in_lpad || in_rpad) pix_d = 8'hFF;
      else if (in_line)                  pix_d = 8'h80;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      state_q      <= ST_SERVE;
      cnt_q        <= '0;
      ball_x_q     <= BALL_X0;
      ball_y_q     <= BALL_Y0;
      dir_r_q      <= 1'b1;
      dir_d_q      <= 1'b1;
      scorer_l_q   <= 1'b0;
      lpad_q       <= PAD_Y0;
      rpad_q       <= PAD_Y0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      pix_q        <= 8'h00;
    end else begin
      vs_q         <= vSync_n;
      frame_tick_q <= tick;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dir_r_q      <= dir_r_d;
      dir_d_q      <= dir_d_d;
      scorer_l_q   <= scorer_l_d;
      lpad_q       <= lpad_d;
      rpad_q       <= rpad_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      pix_q        <= pix_d;
    end
  end

  assign Red          = pix_q;
  assign Green        = pix_q;
  assign Blue         = pix_q;
  assign scoreL       = score_l_q;
  assign scoreR       = score_r_q;
  assign frameTick    = frame_tick_q;
  assign dbg_state_o  = state_q;
  assign dbg_ball_x_o = ball_x_q;
  assign dbg_ball_y_o = ball_y_q;
  assign dbg_lpad_y_o = lpad_q;
  assign dbg_rpad_y_o = rpad_q;

endmodule
